// File: rtl/rv_counter_soc_if.sv
// Debug memory port of rv_counter_soc.
//   dbg_mem_op : 1 = debug owns the memory bus, core stalls
//   dbg_wren   : byte-lane write enables
//   dbg_adr    : byte address, word-aligned
//   dbg_do     : write data
//   dbg_di     : registered read data, valid one cycle after dbg_adr
interface rv_counter_soc_if;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic [31:0] dbg_di;

  modport master (output dbg_mem_op, dbg_wren, dbg_adr, dbg_do, input dbg_di);
  modport slave  (input dbg_mem_op, dbg_wren, dbg_adr, dbg_do, output dbg_di);
endinterface

// File: rtl/rv_counter_soc.sv
// Minimal RV32I SoC: multi-cycle core (FETCH/EXEC[/MEM]), 4 KiB RAM at 0x20000,
// UART transmitter at 0x10000, debug memory port, 64-bit cycle/instret CSRs.
// Ports:
//   CLK, RESET     : clock, async active-high reset (RAM contents survive)
//   PICO_UART0_RX  : unused
//   PICO_UART0_TX  : 8N1 transmit, idle high
//   cpu_hold       : holds core in its reset state
//   dbg            : debug bus (slave side)
module rv_counter_soc #(
  parameter int F_CLK = 12000000,
  parameter int BAUD  = 115200
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            PICO_UART0_RX,
  output logic            PICO_UART0_TX,
  input  logic            cpu_hold,
  rv_counter_soc_if.slave dbg
);
  localparam int          BIT_CYC  = F_CLK / BAUD;
  localparam logic [15:0] BIT_LAST = 16'(BIT_CYC - 1);
  localparam logic [31:0] RESET_PC = 32'h0002_0000;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_JALR  = 7'b1100111,
                         OP_BR  = 7'b1100011, OP_LOAD  = 7'b0000011,
                         OP_ST  = 7'b0100011, OP_IMM   = 7'b0010011,
                         OP_OP  = 7'b0110011, OP_SYS   = 7'b1110011;

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_UART} sel_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_nxt;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [31:0] rf [0:31];
  logic [4:0]  ld_rd;

  // ---------------- memory bus ----------------
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_we;
  logic [31:0] bus_addr, bus_wdata, rdata;
  logic [3:0]  bus_we;
  logic        hit_ram, hit_uart;
  logic [31:0] mem [0:1023];
  logic [31:0] ram_q;
  sel_t        sel_q;
  logic        uart_q;

  logic        tx_busy;
  logic [9:0]  tx_sh;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic        uart_start;

  assign bus_addr  = dbg.dbg_mem_op ? dbg.dbg_adr  : core_addr;
  assign bus_we    = dbg.dbg_mem_op ? dbg.dbg_wren : core_we;
  assign bus_wdata = dbg.dbg_mem_op ? dbg.dbg_do   : core_wdata;

  // Low two address bits are ignored: misaligned accesses hit the whole word.
  assign hit_ram  = bus_addr[31:12] == 20'h00020;
  assign hit_uart = bus_addr[31:2]  == 30'h0000_4000;

  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      if (hit_ram && bus_we[b]) mem[bus_addr[11:2]][8*b +: 8] <= bus_wdata[8*b +: 8];
    ram_q <= mem[bus_addr[11:2]];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sel_q  <= SEL_NONE;
      uart_q <= 1'b0;
    end else begin
      sel_q  <= hit_ram ? SEL_RAM : (hit_uart ? SEL_UART : SEL_NONE);
      uart_q <= tx_busy;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_q == SEL_RAM)       rdata = ram_q;
    else if (sel_q == SEL_UART) rdata = {31'b0, uart_q};
  end

  assign dbg.dbg_di = rdata;

  // ---------------- UART TX ----------------
  assign uart_start = hit_uart && (|bus_we) && !tx_busy;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_busy  <= 1'b0;
      tx_sh    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (uart_start) begin
      tx_busy  <= 1'b1;
      tx_sh    <= {1'b1, bus_wdata[7:0], 1'b0};
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (tx_busy) begin
      if (baud_cnt == BIT_LAST) begin
        baud_cnt <= '0;
        tx_sh    <= {1'b1, tx_sh[9:1]};
        if (bit_cnt == 4'd9) tx_busy <= 1'b0;
        else                 bit_cnt <= bit_cnt + 4'd1;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

  // Combinational from reset flops so RESET forces the line high at once.
  assign PICO_UART0_TX = tx_busy ? tx_sh[0] : 1'b1;

  // ---------------- core decode ----------------
  logic [31:0] ir;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j, alu_b, alu, csr_v;
  logic        taken, go, retire, pc_we, wb_en, ld_latch;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;

  assign ir    = rdata;
  assign opc   = ir[6:0];
  assign rd    = ir[11:7];
  assign f3    = ir[14:12];
  assign rs1   = ir[19:15];
  assign rs2   = ir[24:20];
  assign rs1v  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2v  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign alu_b = (opc == OP_OP) ? rs2v : imm_i;
  assign go    = !RESET && !cpu_hold && !dbg.dbg_mem_op;

  always_comb begin
    alu = '0;
    case (f3)
      3'd0: alu = (opc == OP_OP && ir[30]) ? rs1v - alu_b : rs1v + alu_b;
      3'd1: alu = rs1v << alu_b[4:0];
      3'd2: alu = {31'b0, $signed(rs1v) < $signed(alu_b)};
      3'd3: alu = {31'b0, rs1v < alu_b};
      3'd4: alu = rs1v ^ alu_b;
      3'd5: alu = ir[30] ? 32'($signed(rs1v) >>> alu_b[4:0]) : rs1v >> alu_b[4:0];
      3'd6: alu = rs1v | alu_b;
      default: alu = rs1v & alu_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'd0: taken = rs1v == rs2v;
      3'd1: taken = rs1v != rs2v;
      3'd4: taken = $signed(rs1v) <  $signed(rs2v);
      3'd5: taken = $signed(rs1v) >= $signed(rs2v);
      3'd6: taken = rs1v <  rs2v;
      3'd7: taken = rs1v >= rs2v;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    csr_v = '0;
    case (ir[31:20])
      12'hC00: csr_v = cycle_cnt[31:0];
      12'hC80: csr_v = cycle_cnt[63:32];
      12'hC02: csr_v = instret_cnt[31:0];
      12'hC82: csr_v = instret_cnt[63:32];
      default: csr_v = '0;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= FETCH;
    else       state <= state_n;
  end

  // A debug cycle displaces the RAM read data the core was waiting on, so the
  // core is rewound to FETCH and replays the instruction after release. No
  // architectural state changes before retirement, so the replay is exact.
  always_comb begin
    state_n = state;
    if (cpu_hold || dbg.dbg_mem_op) state_n = FETCH;
    else begin
      case (state)
        FETCH:   state_n = EXEC;
        EXEC:    state_n = (opc == OP_LOAD) ? MEM : FETCH;
        default: state_n = FETCH;
      endcase
    end
  end

  always_comb begin
    core_addr  = pc;
    core_we    = '0;
    core_wdata = rs2v;
    wb_en      = 1'b0;
    wb_rd      = rd;
    wb_val     = '0;
    retire     = 1'b0;
    pc_we      = 1'b0;
    pc_nxt     = pc + 32'd4;
    ld_latch   = 1'b0;
    case (state)
      EXEC: begin
        case (opc)
          OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
          OP_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm_u; end
          OP_JAL:   begin wb_en = 1'b1; wb_val = pc + 32'd4; pc_nxt = pc + imm_j; end
          OP_JALR:  begin wb_en = 1'b1; wb_val = pc + 32'd4; pc_nxt = (rs1v + imm_i) & ~32'd1; end
          OP_BR:    if (taken) pc_nxt = pc + imm_b;
          OP_IMM,
          OP_OP:    begin wb_en = 1'b1; wb_val = alu; end
          OP_LOAD:  begin core_addr = rs1v + imm_i; ld_latch = 1'b1; end
          OP_ST:    begin core_addr = rs1v + imm_s; core_we = 4'hF; end
          OP_SYS:   if (f3 != 3'd0) begin wb_en = 1'b1; wb_val = csr_v; end
          default:  ;
        endcase
        if (opc != OP_LOAD) begin
          retire = 1'b1;
          pc_we  = 1'b1;
        end
      end
      MEM: begin
        wb_en  = 1'b1;
        wb_rd  = ld_rd;
        wb_val = rdata;
        retire = 1'b1;
        pc_we  = 1'b1;
      end
      default: ;
    endcase
    if (!go) begin
      core_we  = '0;
      wb_en    = 1'b0;
      retire   = 1'b0;
      pc_we    = 1'b0;
      ld_latch = 1'b0;
    end
  end

  // ---------------- datapath state ----------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc          <= RESET_PC;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      ld_rd       <= '0;
    end else if (cpu_hold) begin
      pc          <= RESET_PC;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (retire)   instret_cnt <= instret_cnt + 64'd1;
      if (pc_we)    pc          <= pc_nxt;
      if (ld_latch) ld_rd       <= rd;
    end
  end

  always_ff @(posedge CLK) begin
    if (wb_en && wb_rd != 5'd0) rf[wb_rd] <= wb_val;
  end

  logic [2:0] unused_bits;
  assign unused_bits = {PICO_UART0_RX, bus_addr[1:0]};
endmodule

// File: tb/tb_rv_counter_soc.sv
// Directed bench for rv_counter_soc: counter program, debug stall, reset
// mid-run, UART frame at 4 clocks/bit, x0, store + debug byte-lane writes.
module tb_rv_counter_soc;
  logic clk = 1'b0;
  logic rst, hold, rx;
  logic tx;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] rd_d;
  logic [63:0] c0, i0;
  logic [9:0]  frame;

  rv_counter_soc_if dbg();

  rv_counter_soc #(.F_CLK(460800), .BAUD(115200)) dut (
    .CLK(clk), .RESET(rst), .PICO_UART0_RX(rx), .PICO_UART0_TX(tx),
    .cpu_hold(hold), .dbg(dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic dbg_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    dbg.dbg_mem_op = 1'b1; dbg.dbg_adr = a; dbg.dbg_do = d; dbg.dbg_wren = be;
    @(negedge clk);
    dbg.dbg_wren = 4'b0; dbg.dbg_mem_op = 1'b0;
  endtask

  task automatic dbg_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    dbg.dbg_mem_op = 1'b1; dbg.dbg_adr = a; dbg.dbg_wren = 4'b0;
    @(negedge clk);
    d = dbg.dbg_di;
    dbg.dbg_mem_op = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b1; rx = 1'b1;
    dbg.dbg_mem_op = 1'b0; dbg.dbg_wren = 4'b0; dbg.dbg_adr = '0; dbg.dbg_do = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",  64'(tx), 64'd1);
    chk("rst_di",  64'(dbg.dbg_di), 64'd0);
    chk("rst_pc",  64'(dut.pc), 64'h20000);
    chk("rst_cyc", dut.cycle_cnt, 64'd0);
    @(negedge clk) rst = 1'b0;

    // counter program: 3 x add x0, rdinstret a0, rdcycle a0, j .
    dbg_wr(32'h20000, 32'h00000033, 4'hF);
    dbg_wr(32'h20004, 32'h00000033, 4'hF);
    dbg_wr(32'h20008, 32'h00000033, 4'hF);
    dbg_wr(32'h2000C, 32'hC0202573, 4'hF);
    dbg_wr(32'h20010, 32'hC0002573, 4'hF);
    dbg_wr(32'h20014, 32'h0000006F, 4'hF);
    @(negedge clk) hold = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("rdinstret", 64'(dut.rf[10]), 64'd3);
    repeat (2) @(posedge clk);
    #1 chk("rdcycle", 64'(dut.rf[10]), 64'd9);
    repeat (20) @(posedge clk);
    #1;
    chk("loop_pc", 64'(dut.pc), 64'h20014);
    chk("cyc30",   dut.cycle_cnt, 64'd30);
    i0 = dut.instret_cnt;
    repeat (4) @(posedge clk);
    #1 chk("instret_run", dut.instret_cnt, i0 + 64'd2);

    // debug stall for 10 cycles
    @(negedge clk);
    dbg.dbg_mem_op = 1'b1; dbg.dbg_adr = 32'h20100; dbg.dbg_wren = 4'b0;
    c0 = dut.cycle_cnt; i0 = dut.instret_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_cyc", dut.cycle_cnt, c0 + 64'd10);
    chk("stall_ret", dut.instret_cnt, i0);
    chk("stall_pc",  64'(dut.pc), 64'h20014);
    @(negedge clk) dbg.dbg_mem_op = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("post_stall_ret", dut.instret_cnt, i0 + 64'd5);

    // reset mid-run; program must survive and re-run identically
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_rst_tx",  64'(tx), 64'd1);
    chk("mid_rst_cyc", dut.cycle_cnt, 64'd0);
    chk("mid_rst_ret", dut.instret_cnt, 64'd0);
    chk("mid_rst_pc",  64'(dut.pc), 64'h20000);
    @(negedge clk) rst = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("rdinstret2", 64'(dut.rf[10]), 64'd3);
    repeat (2) @(posedge clk);
    #1 chk("rdcycle2", 64'(dut.rf[10]), 64'd9);

    // UART / x0 / store program
    @(negedge clk) hold = 1'b1;
    dbg_wr(32'h20000, 32'h000105B7, 4'hF); // lui a1,0x10
    dbg_wr(32'h20004, 32'h05500293, 4'hF); // addi t0,x0,0x55
    dbg_wr(32'h20008, 32'h0055A023, 4'hF); // sw t0,0(a1)
    dbg_wr(32'h2000C, 32'h00500013, 4'hF); // addi x0,x0,5
    dbg_wr(32'h20010, 32'h00000533, 4'hF); // add a0,x0,x0
    dbg_wr(32'h20014, 32'hDEADC337, 4'hF); // lui t1,0xDEADC
    dbg_wr(32'h20018, 32'hEEF30313, 4'hF); // addi t1,t1,-0x111
    dbg_wr(32'h2001C, 32'h000203B7, 4'hF); // lui t2,0x20
    dbg_wr(32'h20020, 32'h1063A023, 4'hF); // sw t1,0x100(t2)
    dbg_wr(32'h20024, 32'h0000006F, 4'hF); // j .
    @(negedge clk) hold = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("tx_idle", 64'(tx), 64'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        #1 chk($sformatf("tx_b%0d_c%0d", b, c), 64'(tx), 64'(frame[b]));
        if (c == 0) chk($sformatf("busy_b%0d", b), 64'(dut.tx_busy), 64'd1);
      end
    end
    @(posedge clk);
    #1;
    chk("busy_done", 64'(dut.tx_busy), 64'd0);
    chk("tx_done",   64'(tx), 64'd1);
    chk("x0_a0",     64'(dut.rf[10]), 64'd0);

    @(negedge clk) hold = 1'b1;
    dbg_rd(32'h20100, rd_d);
    chk("sw_readback", 64'(rd_d), 64'hDEADBEEF);
    dbg_wr(32'h20100, 32'h0000AA00, 4'b0010);   // lane 1 = bits 15:8
    dbg_rd(32'h20100, rd_d);
    chk("byte_lane", 64'(rd_d), 64'hDEADAAEF);
    dbg_rd(32'h10000, rd_d);
    chk("uart_idle_rd", 64'(rd_d), 64'd0);
    dbg_rd(32'h30000, rd_d);
    chk("unmapped_rd", 64'(rd_d), 64'd0);
    dbg_rd(32'h20000, rd_d);
    chk("prog_intact", 64'(rd_d), 64'h000105B7);

    // second frame: busy readable over debug, then RESET mid-frame
    @(negedge clk) hold = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("tx_start2", 64'(tx), 64'd0);
    dbg_rd(32'h10000, rd_d);
    chk("uart_busy_rd", 64'(rd_d), 64'd1);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("rst_frame_tx",   64'(tx), 64'd1);
    chk("rst_frame_busy", 64'(dut.tx_busy), 64'd0);
    @(negedge clk) begin rst = 1'b0; hold = 1'b1; end
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
